sd_ctrl_regbank: RTL
====================

# sd_ctrl_regbank

Parametrised host-side register bank for the SD card controller. It replaces the fixed 8-bit, unhandshaked register port with a configurable-width byte-enabled bus using a request/acknowledge handshake and registered read data. It owns the sticky, write-1-to-clear interrupt status registers and generates the `cmd_start`, `cmd_int_rst` and `data_int_rst` strobes. It sits between the host bus bridge and the command/data master FSMs, in one clock domain.

## Interface
- `DATA_W`, 32: bus width; legal values 8, 16, 32.
- `ADDR_W`, 7: byte-address width.
- `INT_CMD_W`, 5: command interrupt bit count.
- `INT_DATA_W`, 3: data interrupt bit count.
- `BLKSIZE_W`, 12 / `BLKCNT_W`, 16: block size and block count widths.
- `RESET_BLOCK_SIZE`, 511: reset value of `block_size`.
- `clk` in 1: the only clock.
- `rst` in 1: **asynchronous, active-high reset**.
- `req` in 1: access request.
- `we` in 1: write when 1, read when 0.
- `addr` in ADDR_W: byte address, aligned to DATA_W/8.
- `be` in DATA_W/8: byte-lane enables.
- `wdata` in DATA_W: write data.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out DATA_W: read data, valid while `ack`=1.
- `resp0`..`resp3` in 32 each: response words; read-only.
- `cmd_int_evt` in INT_CMD_W: single-cycle set pulses for command interrupt status.
- `data_int_evt` in INT_DATA_W: single-cycle set pulses for data interrupt status.
- `argument`, `command`, `sw_reset`, `cmd_timeout`, `data_timeout`, `block_size`, `ctrl_setting`, `cmd_int_en`, `clock_div`, `block_count`, `dma_addr` out: configuration registers. Widths match the existing controller widths.
- `cmd_int_status` out INT_CMD_W: sticky command interrupt status.
- `data_int_status` out INT_DATA_W: sticky data interrupt status.
- `cmd_start` out 1: single-cycle strobe.
- `cmd_int_rst` out 1: single-cycle strobe.
- `data_int_rst` out 1: single-cycle strobe.
- `cmd_irq` out 1: `|(cmd_int_status & cmd_int_en)`.
- `data_irq` out 1: `|(data_int_status & data_int_en)`.

## Operation
- **Word index:** `addr[ADDR_W-1:2]`. Lane `i` maps to register byte `addr[1:0]+i`.
  - Enabled lanes beyond byte 3 are ignored.
  - Bytes above a register's width are ignored on write and read as 0.
- **Handshake (classic):** a request is accepted when `req`=1 and `ack`=0.
  - `ack`=1 on the next cycle.
  - The host holds `req`/`addr`/`we`/`be`/`wdata` stable until `ack`.
  - Peak throughput is one access per 2 cycles.
- **Writes** take effect in the acceptance cycle; the new value is visible from the next cycle.
  - Writes to `resp*`, `voltage` and `capa` are ignored.
  - Writes to unmapped offsets are ignored, and `ack` is still given.
- **Strobes** assert in the cycle after acceptance, for one cycle:
  - `cmd_start` on any write to `argument` that enables register byte 3.
  - `cmd_int_rst` on any write to `cmd_isr`.
  - `data_int_rst` on any write to `data_isr`.
- **Interrupt status:** each bit sets on its event pulse.
  - Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - If set and clear occur in the same cycle, set wins.
- **Reads:** `rdata` is registered from the acceptance cycle.
  - Unmapped offsets return 0.
  - `voltage` returns `SUPPLY_VOLTAGE_mV`; `capa` returns 0.
  - Lanes with `be`=0 return 0.
- **Reset mid-access:** asserting `rst` drops `ack` immediately. The access is lost and the host must reissue it.

## Timing
- **Reset values:**
  - `ack`, `rdata`, strobes, IRQs, all status bits: 0.
  - All configuration registers: 0, except `block_size`=RESET_BLOCK_SIZE.
- Read latency is 1 cycle from acceptance.
- An event pulse appears in `*_int_status` 1 cycle later; the IRQ follows combinationally.
- `ack` is never high on two consecutive cycles.

## Configuration
- **`SD_REGBANK_RDBACK_EN` defined:** write-only configuration registers read back their contents: argument, command, sw_reset, timeouts, block_size, ctrl_setting, enables, clock_div, block_count, dma_addr.
- **Undefined:** those offsets read as 0. Status, `resp*`, `voltage` and `capa` stay readable.

## Structure
- **Package `sd_regbank_pkg`:** register offset localparams (values identical to `sd_defines.h`), default widths, and a `reg_id_e` enum for the decoded word index.
- **Sub-module `sd_lane_reg`:** parametrised width, reset value and async reset. Byte-lane write enables; one instance per configuration register.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately; read `blksize` → 0x1FF.
- **32-bit lane write:** DATA_W=32, write `argument`=0x12345678 with `be`=4'b0111 → `argument`=0x00345678 and no `cmd_start`. Then write `be`=4'b1000 → `argument`=0x12345678 and one `cmd_start` pulse.
- **8-bit bus:** DATA_W=8, write 0xAB to `argument`+3 → `argument`[31:24]=0xAB, `cmd_start`=1 for 1 cycle, `ack` 1 cycle after `req`.
- **W1C:** pulse `cmd_int_evt`=5'b00101 with `cmd_int_en`=5'b00100 → `cmd_irq`=1. Write 0x04 to `cmd_isr` → status 5'b00001, `cmd_irq`=0, `cmd_int_rst` pulse.
- **Set/clear collision:** `data_int_evt`[1] pulses in the same cycle that 0x02 is written to `data_isr` → bit 1 remains 1.
- **Readback configuration:** write `clock_d`=0x7F, then read it → 0x7F with `SD_REGBANK_RDBACK_EN`, 0x00 without. Read `resp2` with input 0xDEADBEEF → 0xDEADBEEF either way.

Source files
------------

// File: rtl/sd_regbank_pkg.sv
// ---------------------------------------------------------------------------
// sd_regbank_pkg
// Shared definitions for the SD controller host register bank:
//   - byte offsets of every register (same values as sd_defines.h)
//   - default parameter values and fixed controller register widths
//   - reg_id_e: decoded word index (byte offset >> 2)
//   - nbytes(): number of byte lanes covering a register of a given width
// ---------------------------------------------------------------------------
package sd_regbank_pkg;

    localparam logic [7:0] ADDR_ARGUMENT     = 8'h00;
    localparam logic [7:0] ADDR_COMMAND      = 8'h04;
    localparam logic [7:0] ADDR_RESP0        = 8'h08;
    localparam logic [7:0] ADDR_RESP1        = 8'h0C;
    localparam logic [7:0] ADDR_RESP2        = 8'h10;
    localparam logic [7:0] ADDR_RESP3        = 8'h14;
    localparam logic [7:0] ADDR_DATA_TIMEOUT = 8'h18;
    localparam logic [7:0] ADDR_CONTROLLER   = 8'h1C;
    localparam logic [7:0] ADDR_CMD_TIMEOUT  = 8'h20;
    localparam logic [7:0] ADDR_CLOCK_D      = 8'h24;
    localparam logic [7:0] ADDR_RESET        = 8'h28;
    localparam logic [7:0] ADDR_VOLTAGE      = 8'h2C;
    localparam logic [7:0] ADDR_CAPA         = 8'h30;
    localparam logic [7:0] ADDR_CMD_ISR      = 8'h34;
    localparam logic [7:0] ADDR_CMD_ISER     = 8'h38;
    localparam logic [7:0] ADDR_DATA_ISR     = 8'h3C;
    localparam logic [7:0] ADDR_DATA_ISER    = 8'h40;
    localparam logic [7:0] ADDR_BLKSIZE      = 8'h44;
    localparam logic [7:0] ADDR_BLKCNT       = 8'h48;
    localparam logic [7:0] ADDR_DST_SRC_ADDR = 8'h60;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_INT_CMD_W  = 5;
    localparam int DEF_INT_DATA_W = 3;
    localparam int DEF_BLKSIZE_W  = 12;
    localparam int DEF_BLKCNT_W   = 16;

    localparam int ARG_W          = 32;
    localparam int CMD_REG_W      = 14;
    localparam int CMD_TIMEOUT_W  = 24;
    localparam int DATA_TIMEOUT_W = 24;
    localparam int CTRL_W         = 16;
    localparam int CLKDIV_W       = 8;
    localparam int DMA_ADDR_W     = 32;

    localparam logic [31:0] SUPPLY_VOLTAGE_mV = 32'd3300;

    typedef enum logic [4:0] {
        REG_ARGUMENT     = ADDR_ARGUMENT[6:2],
        REG_COMMAND      = ADDR_COMMAND[6:2],
        REG_RESP0        = ADDR_RESP0[6:2],
        REG_RESP1        = ADDR_RESP1[6:2],
        REG_RESP2        = ADDR_RESP2[6:2],
        REG_RESP3        = ADDR_RESP3[6:2],
        REG_DATA_TIMEOUT = ADDR_DATA_TIMEOUT[6:2],
        REG_CONTROLLER   = ADDR_CONTROLLER[6:2],
        REG_CMD_TIMEOUT  = ADDR_CMD_TIMEOUT[6:2],
        REG_CLOCK_D      = ADDR_CLOCK_D[6:2],
        REG_RESET        = ADDR_RESET[6:2],
        REG_VOLTAGE      = ADDR_VOLTAGE[6:2],
        REG_CAPA         = ADDR_CAPA[6:2],
        REG_CMD_ISR      = ADDR_CMD_ISR[6:2],
        REG_CMD_ISER     = ADDR_CMD_ISER[6:2],
        REG_DATA_ISR     = ADDR_DATA_ISR[6:2],
        REG_DATA_ISER    = ADDR_DATA_ISER[6:2],
        REG_BLKSIZE      = ADDR_BLKSIZE[6:2],
        REG_BLKCNT       = ADDR_BLKCNT[6:2],
        REG_DST_SRC_ADDR = ADDR_DST_SRC_ADDR[6:2]
    } reg_id_e;

    function automatic int nbytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/sd_lane_reg.sv
// ---------------------------------------------------------------------------
// sd_lane_reg
// One configuration register of width W with per-byte write enables and an
// asynchronous, active-high reset to RST_VAL.
// Ports:
//   clk, rst  : clock, async active-high reset
//   wr        : register selected for write this cycle
//   bmask     : byte enables, bit k covers q[8k+7:8k] (top byte may be partial)
//   d         : write data, already aligned to register byte positions
//   q         : register contents
// ---------------------------------------------------------------------------
module sd_lane_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [(W+7)/8-1:0]     bmask,
    input  logic [W-1:0]           d,
    output logic [W-1:0]           q
);

    localparam int NB = (W + 7) / 8;

    for (genvar k = 0; k < NB; k++) begin : g_byte
        localparam int LO = k * 8;
        localparam int HI = (LO + 8 > W) ? W - 1 : LO + 7;

        logic [HI-LO:0] r;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r <= RST_VAL[HI:LO];
            end else if (wr && bmask[k]) begin
                r <= d[HI:LO];
            end
        end

        assign q[HI:LO] = r;
    end

endmodule

// File: rtl/sd_ctrl_regbank.sv
// ---------------------------------------------------------------------------
// sd_ctrl_regbank
// Host-side register bank of the SD card controller. Byte-enabled
// request/acknowledge bus (one access per two cycles), registered read data,
// sticky write-1-to-clear interrupt status, and cmd_start / cmd_int_rst /
// data_int_rst strobes for the command and data master FSMs.
//
// Build option: SD_REGBANK_RDBACK_EN - when defined, the write-only
// configuration registers read back their contents; otherwise they read 0.
//
// Ports:
//   clk, rst                 : clock, async active-high reset
//   req, we, addr, be, wdata : host access (held stable until ack)
//   ack, rdata               : one-cycle completion pulse, read data
//   resp0..resp3             : read-only response words
//   cmd_int_evt/data_int_evt : interrupt set pulses
//   argument .. dma_addr     : configuration register outputs
//   cmd_int_status, data_int_status : sticky interrupt status
//   cmd_start, cmd_int_rst, data_int_rst : one-cycle strobes
//   cmd_irq, data_irq        : masked interrupt requests
// ---------------------------------------------------------------------------
module sd_ctrl_regbank
    import sd_regbank_pkg::*;
#(
    parameter int DATA_W           = DEF_DATA_W,
    parameter int ADDR_W           = DEF_ADDR_W,
    parameter int INT_CMD_W        = DEF_INT_CMD_W,
    parameter int INT_DATA_W       = DEF_INT_DATA_W,
    parameter int BLKSIZE_W        = DEF_BLKSIZE_W,
    parameter int BLKCNT_W         = DEF_BLKCNT_W,
    parameter int RESET_BLOCK_SIZE = 511
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W/8-1:0]       be,
    input  logic [DATA_W-1:0]         wdata,
    output logic                      ack,
    output logic [DATA_W-1:0]         rdata,
    input  logic [31:0]               resp0,
    input  logic [31:0]               resp1,
    input  logic [31:0]               resp2,
    input  logic [31:0]               resp3,
    input  logic [INT_CMD_W-1:0]      cmd_int_evt,
    input  logic [INT_DATA_W-1:0]     data_int_evt,
    output logic [ARG_W-1:0]          argument,
    output logic [CMD_REG_W-1:0]      command,
    output logic                      sw_reset,
    output logic [CMD_TIMEOUT_W-1:0]  cmd_timeout,
    output logic [DATA_TIMEOUT_W-1:0] data_timeout,
    output logic [BLKSIZE_W-1:0]      block_size,
    output logic [CTRL_W-1:0]         ctrl_setting,
    output logic [INT_CMD_W-1:0]      cmd_int_en,
    output logic [CLKDIV_W-1:0]       clock_div,
    output logic [BLKCNT_W-1:0]       block_count,
    output logic [DMA_ADDR_W-1:0]     dma_addr,
    output logic [INT_CMD_W-1:0]      cmd_int_status,
    output logic [INT_DATA_W-1:0]     data_int_status,
    output logic                      cmd_start,
    output logic                      cmd_int_rst,
    output logic                      data_int_rst,
    output logic                      cmd_irq,
    output logic                      data_irq
);

    localparam int NB = DATA_W / 8;

    logic                  accept;
    logic [ADDR_W-3:0]     widx_full;
    logic                  hit;
    reg_id_e               reg_id;
    logic                  wr_cmn;
    logic [3:0]            wmask;
    logic [31:0]           wword;
    logic [31:0]           rword;
    logic [DATA_W-1:0]     rd_lanes;
    logic [NB-1:0]         lane_ok;
    logic [1:0]            lane_byte [NB];
    logic [INT_CMD_W-1:0]  cmd_clr;
    logic [INT_DATA_W-1:0] data_clr;
    logic [INT_DATA_W-1:0] data_int_en;

    assign accept    = req & ~ack;
    assign widx_full = addr[ADDR_W-1:2];
    // Word indices beyond the 32-entry map never select a register.
    assign hit       = (widx_full >> 5) == '0;
    assign reg_id    = reg_id_e'(widx_full[4:0]);
    assign wr_cmn    = accept & we & hit;

    // Lane i lands on register byte addr[1:0]+i; lanes past byte 3 drop out.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [2:0] bsum;
        assign bsum         = {1'b0, addr[1:0]} + 3'(i);
        assign lane_ok[i]   = be[i] & ~bsum[2];
        assign lane_byte[i] = bsum[1:0];
    end

    always_comb begin
        wmask = '0;
        wword = '0;
        for (int i = 0; i < NB; i++) begin
            if (lane_ok[i]) begin
                wmask[lane_byte[i]]                = 1'b1;
                wword[{lane_byte[i], 3'b000} +: 8] = wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_lanes = '0;
        for (int i = 0; i < NB; i++) begin
            if (lane_ok[i]) begin
                rd_lanes[i*8 +: 8] = rword[{lane_byte[i], 3'b000} +: 8];
            end
        end
    end

    sd_lane_reg #(.W(ARG_W), .RST_VAL('0)) u_argument (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_ARGUMENT),
        .bmask(wmask[nbytes(ARG_W)-1:0]), .d(wword[ARG_W-1:0]), .q(argument));

    sd_lane_reg #(.W(CMD_REG_W), .RST_VAL('0)) u_command (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_COMMAND),
        .bmask(wmask[nbytes(CMD_REG_W)-1:0]), .d(wword[CMD_REG_W-1:0]), .q(command));

    sd_lane_reg #(.W(1), .RST_VAL('0)) u_sw_reset (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_RESET),
        .bmask(wmask[0:0]), .d(wword[0:0]), .q(sw_reset));

    sd_lane_reg #(.W(CMD_TIMEOUT_W), .RST_VAL('0)) u_cmd_timeout (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_CMD_TIMEOUT),
        .bmask(wmask[nbytes(CMD_TIMEOUT_W)-1:0]), .d(wword[CMD_TIMEOUT_W-1:0]),
        .q(cmd_timeout));

    sd_lane_reg #(.W(DATA_TIMEOUT_W), .RST_VAL('0)) u_data_timeout (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_DATA_TIMEOUT),
        .bmask(wmask[nbytes(DATA_TIMEOUT_W)-1:0]), .d(wword[DATA_TIMEOUT_W-1:0]),
        .q(data_timeout));

    sd_lane_reg #(.W(BLKSIZE_W), .RST_VAL(BLKSIZE_W'(RESET_BLOCK_SIZE))) u_block_size (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_BLKSIZE),
        .bmask(wmask[nbytes(BLKSIZE_W)-1:0]), .d(wword[BLKSIZE_W-1:0]), .q(block_size));

    sd_lane_reg #(.W(CTRL_W), .RST_VAL('0)) u_ctrl_setting (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_CONTROLLER),
        .bmask(wmask[nbytes(CTRL_W)-1:0]), .d(wword[CTRL_W-1:0]), .q(ctrl_setting));

    sd_lane_reg #(.W(INT_CMD_W), .RST_VAL('0)) u_cmd_int_en (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_CMD_ISER),
        .bmask(wmask[nbytes(INT_CMD_W)-1:0]), .d(wword[INT_CMD_W-1:0]), .q(cmd_int_en));

    sd_lane_reg #(.W(INT_DATA_W), .RST_VAL('0)) u_data_int_en (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_DATA_ISER),
        .bmask(wmask[nbytes(INT_DATA_W)-1:0]), .d(wword[INT_DATA_W-1:0]), .q(data_int_en));

    sd_lane_reg #(.W(CLKDIV_W), .RST_VAL('0)) u_clock_div (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_CLOCK_D),
        .bmask(wmask[nbytes(CLKDIV_W)-1:0]), .d(wword[CLKDIV_W-1:0]), .q(clock_div));

    sd_lane_reg #(.W(BLKCNT_W), .RST_VAL('0)) u_block_count (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_BLKCNT),
        .bmask(wmask[nbytes(BLKCNT_W)-1:0]), .d(wword[BLKCNT_W-1:0]), .q(block_count));

    sd_lane_reg #(.W(DMA_ADDR_W), .RST_VAL('0)) u_dma_addr (
        .clk(clk), .rst(rst), .wr(wr_cmn && reg_id == REG_DST_SRC_ADDR),
        .bmask(wmask[nbytes(DMA_ADDR_W)-1:0]), .d(wword[DMA_ADDR_W-1:0]), .q(dma_addr));

    // Read word before lane selection; all register fields zero-extended.
    always_comb begin
        rword = '0;
        if (hit) begin
            case (reg_id)
                REG_RESP0:        rword = resp0;
                REG_RESP1:        rword = resp1;
                REG_RESP2:        rword = resp2;
                REG_RESP3:        rword = resp3;
                REG_VOLTAGE:      rword = SUPPLY_VOLTAGE_mV;
                REG_CAPA:         rword = '0;
                REG_CMD_ISR:      rword = 32'(cmd_int_status);
                REG_DATA_ISR:     rword = 32'(data_int_status);
`ifdef SD_REGBANK_RDBACK_EN
                REG_ARGUMENT:     rword = 32'(argument);
                REG_COMMAND:      rword = 32'(command);
                REG_RESET:        rword = 32'(sw_reset);
                REG_CMD_TIMEOUT:  rword = 32'(cmd_timeout);
                REG_DATA_TIMEOUT: rword = 32'(data_timeout);
                REG_BLKSIZE:      rword = 32'(block_size);
                REG_CONTROLLER:   rword = 32'(ctrl_setting);
                REG_CMD_ISER:     rword = 32'(cmd_int_en);
                REG_DATA_ISER:    rword = 32'(data_int_en);
                REG_CLOCK_D:      rword = 32'(clock_div);
                REG_BLKCNT:       rword = 32'(block_count);
                REG_DST_SRC_ADDR: rword = 32'(dma_addr);
`endif
                default:          rword = '0;
            endcase
        end
    end

    // Write-1-to-clear masks; status bits live in register byte 0.
    assign cmd_clr  = (wr_cmn && reg_id == REG_CMD_ISR && wmask[0])
                      ? wword[INT_CMD_W-1:0] : '0;
    assign data_clr = (wr_cmn && reg_id == REG_DATA_ISR && wmask[0])
                      ? wword[INT_DATA_W-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack             <= 1'b0;
            rdata           <= '0;
            cmd_start       <= 1'b0;
            cmd_int_rst     <= 1'b0;
            data_int_rst    <= 1'b0;
            cmd_int_status  <= '0;
            data_int_status <= '0;
        end else begin
            ack             <= accept;
            rdata           <= (accept && !we) ? rd_lanes : '0;
            cmd_start       <= wr_cmn && reg_id == REG_ARGUMENT && wmask[3];
            cmd_int_rst     <= wr_cmn && reg_id == REG_CMD_ISR;
            data_int_rst    <= wr_cmn && reg_id == REG_DATA_ISR;
            // Event OR'd in after the clear so a simultaneous set wins.
            cmd_int_status  <= (cmd_int_status & ~cmd_clr) | cmd_int_evt;
            data_int_status <= (data_int_status & ~data_clr) | data_int_evt;
        end
    end

    assign cmd_irq  = |(cmd_int_status & cmd_int_en);
    assign data_irq = |(data_int_status & data_int_en);

endmodule
